adder_issue_ctrl: RTL and testbench

- Shares one 4-stage pipelined 32-bit adder (Pipeline_adder) between two requesters.
- Arbitrates issue round-robin and tags each operation.
- Keeps a 4-stage shadow tag/valid pipeline in lockstep with the adder and routes each result to its owner.
- Drives the adder's suspend/refresh/out_allow controls for backpressure and per-requester flush.

---
 rtl/adder_issue_ctrl_pkg.sv | 20 ++
 rtl/adder_issue_ctrl_arb.sv | 40 ++++
 rtl/adder_issue_ctrl.sv | 117 +++++++++++
 tb/tb_adder_issue_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_adder_pkg
// Brief    : Shared types and constants for the shared pipelined-adder issue logic
// Revision : 1.0
// ============================================================================
package pipeline_adder_pkg;

    localparam int ADD_STAGES = 4;
    localparam int ADD_WIDTH  = 32;

    typedef logic tag_t;

    typedef struct packed {
        logic valid;
        tag_t tag;
    } stage_t;

endpackage
`default_nettype wire

// File: rtl/adder_issue_ctrl_arb.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_2
// Brief    : Two-way round-robin arbiter; pointer moves past the winner on grant
// Revision : 1.0
// ============================================================================
module rr_arbiter_2
    import pipeline_adder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] eligible,
    output logic [1:0] grant,
    output tag_t       winner
);

    tag_t r_prio;

    always_comb begin
        grant  = 2'b00;
        winner = r_prio;
        if (eligible[r_prio]) begin
            grant[r_prio] = 1'b1;
            winner        = r_prio;
        end else if (eligible[~r_prio]) begin
            grant[~r_prio] = 1'b1;
            winner         = ~r_prio;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prio <= 1'b0;
        end else if (|grant) begin
            r_prio <= ~winner;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adder_issue_ctrl
// Brief    : Shares a 4-stage pipelined adder between two requesters with a
//            lockstep shadow tag pipeline, backpressure and per-requester flush
// Revision : 1.0
// ============================================================================
module adder_issue_ctrl
    import pipeline_adder_pkg::*;
#(
    parameter int WIDTH    = ADD_WIDTH,
    parameter int N_STAGES = ADD_STAGES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [1:0]         req_cin,
    input  logic [1:0]         flush,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [WIDTH-1:0]   rsp_sum,
    output logic               rsp_cout,
    output logic               add_validin,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    output logic               add_out_allow,
    output logic [4:1]         add_suspend,
    output logic [4:1]         add_refresh,
    input  logic               add_validout,
    input  logic [WIDTH-1:0]   add_sum,
    input  logic               add_cout,
    output logic [2:0]         inflight,
    output logic               err
);

    stage_t [N_STAGES:1] r_stg;
    logic                r_purge;
    logic                r_err;

    logic [1:0]          w_grant;
    tag_t                w_winner;
    tag_t                w_head_tag;
    logic                w_head_kill;
    logic                w_stall;
    logic [1:0]          w_eligible;
    logic [N_STAGES:1]   w_refresh;
    logic [2:0]          w_cnt;

    assign w_head_tag  = r_stg[N_STAGES].tag;
    assign w_head_kill = r_stg[N_STAGES].valid & flush[w_head_tag];
    assign w_stall     = r_stg[N_STAGES].valid & ~w_head_kill & ~rsp_ready[w_head_tag];
    // Nothing issues while the head is stuck or while the adder is being purged
    assign w_eligible  = req_valid & ~flush & {2{~w_stall & ~r_purge}};

    rr_arbiter_2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .eligible (w_eligible),
        .grant    (w_grant),
        .winner   (w_winner)
    );

    always_comb begin
        w_refresh = '0;
        w_cnt     = 3'd0;
        for (int j = 1; j <= N_STAGES; j++) begin
            w_refresh[j] = r_purge | (r_stg[j].valid & flush[r_stg[j].tag]);
            w_cnt        = w_cnt + {2'b00, r_stg[j].valid};
        end
    end

    assign req_ready     = w_grant;
    assign add_validin   = |w_grant;
    assign add_a         = w_winner ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    assign add_b         = w_winner ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
    assign add_cin       = req_cin[w_winner];
    assign add_suspend   = {4{w_stall}};
    assign add_out_allow = ~w_stall;
    assign add_refresh   = w_refresh;

    assign rsp_valid = (r_stg[N_STAGES].valid & ~w_head_kill) ?
                       (w_head_tag ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_sum   = add_sum;
    assign rsp_cout  = add_cout;
    assign inflight  = w_cnt;
    assign err       = r_err;

    // A refreshed stage kills the op it holds, so that op never reaches the next stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stg   <= '0;
            r_purge <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_purge <= 1'b0;
            r_err   <= r_err | (~r_purge & (add_validout != r_stg[N_STAGES].valid));
            if (w_stall) begin
                for (int j = 1; j <= N_STAGES; j++) begin
                    r_stg[j].valid <= r_stg[j].valid & ~w_refresh[j];
                end
            end else begin
                r_stg[1].valid <= |w_grant;
                r_stg[1].tag   <= w_winner;
                for (int j = 2; j <= N_STAGES; j++) begin
                    r_stg[j].valid <= r_stg[j-1].valid & ~w_refresh[j-1];
                    r_stg[j].tag   <= r_stg[j-1].tag;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_issue_ctrl
// Brief    : Directed self-checking bench with a behavioural 4-stage adder model
// Revision : 1.0
// ============================================================================
module tb_adder_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid, req_ready, req_cin, flush, rsp_valid, rsp_ready;
    logic [63:0] req_a, req_b;
    logic [31:0] rsp_sum, add_a, add_b, add_sum;
    logic        rsp_cout, add_validin, add_cin, add_out_allow, add_validout, add_cout;
    logic [4:1]  add_suspend, add_refresh;
    logic [2:0]  inflight;
    logic        err;

    int vectors     = 0;
    int miscompares = 0;

    adder_issue_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_cin       (req_cin),
        .flush         (flush),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_sum       (rsp_sum),
        .rsp_cout      (rsp_cout),
        .add_validin   (add_validin),
        .add_a         (add_a),
        .add_b         (add_b),
        .add_cin       (add_cin),
        .add_out_allow (add_out_allow),
        .add_suspend   (add_suspend),
        .add_refresh   (add_refresh),
        .add_validout  (add_validout),
        .add_sum       (add_sum),
        .add_cout      (add_cout),
        .inflight      (inflight),
        .err           (err)
    );

    always #5 clk = ~clk;

    // Behavioural shared adder; starts with stale valid bits that only a purge removes
    logic [4:1]  mv = 4'b1010;
    logic [32:0] ms [1:4];

    always @(posedge clk) begin
        if (add_suspend == 4'b1111 && !add_out_allow) begin
            for (int j = 1; j <= 4; j++) mv[j] <= mv[j] & ~add_refresh[j];
        end else begin
            mv[1] <= add_validin;
            ms[1] <= {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
            for (int j = 2; j <= 4; j++) begin
                mv[j] <= mv[j-1] & ~add_refresh[j-1];
                ms[j] <= ms[j-1];
            end
        end
    end

    assign add_validout = mv[4];
    assign add_sum      = ms[4][31:0];
    assign add_cout     = ms[4][32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic phase();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 2'b11; req_cin = 2'b00; flush = 2'b00; rsp_ready = 2'b11;
        req_a = '0; req_b = '0;
        #2 rst = 1'b0;
        repeat (2) phase();
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_validin", 64'(add_validin), 64'h0);
        chk("rst_suspend", 64'(add_suspend), 64'h0);
        chk("rst_out_allow", 64'(add_out_allow), 64'h1);
        chk("rst_inflight", 64'(inflight), 64'h0);
        chk("rst_err", 64'(err), 64'h0);

        // Purge cycle, then contention: grants 0,1,0,1
        phase(); rst = 1'b1;
        req_a = {32'd20, 32'd10}; req_b = {32'd1, 32'd1};
        #1;
        chk("purge_refresh", 64'(add_refresh), 64'hf);
        chk("purge_no_grant", 64'(req_ready), 64'h0);
        phase(); #1;
        chk("cont_g0", 64'(req_ready), 64'h1);
        chk("cont_refresh_off", 64'(add_refresh), 64'h0);
        chk("cont_add_a0", 64'(add_a), 64'd10);
        phase(); #1;
        chk("cont_g1", 64'(req_ready), 64'h2);
        chk("cont_add_a1", 64'(add_a), 64'd20);
        phase(); #1;
        chk("cont_g2", 64'(req_ready), 64'h1);
        phase(); #1;
        chk("cont_g3", 64'(req_ready), 64'h2);
        chk("cont_inflight3", 64'(inflight), 64'd3);
        phase(); req_valid = 2'b00; #1;
        chk("cont_r0_valid", 64'(rsp_valid), 64'h1);
        chk("cont_r0_sum", 64'(rsp_sum), 64'd11);
        chk("cont_inflight4", 64'(inflight), 64'd4);
        phase(); #1;
        chk("cont_r1_valid", 64'(rsp_valid), 64'h2);
        chk("cont_r1_sum", 64'(rsp_sum), 64'd21);
        phase(); #1;
        chk("cont_r2_valid", 64'(rsp_valid), 64'h1);
        chk("cont_r2_sum", 64'(rsp_sum), 64'd11);
        phase(); #1;
        chk("cont_r3_valid", 64'(rsp_valid), 64'h2);
        chk("cont_r3_sum", 64'(rsp_sum), 64'd21);

        // Single op 1+2
        phase(); req_valid = 2'b01; req_a = {32'd0, 32'd1}; req_b = {32'd0, 32'd2}; #1;
        chk("single_drained", 64'(rsp_valid), 64'h0);
        chk("single_grant", 64'(req_ready), 64'h1);
        phase(); req_valid = 2'b00; #1;
        chk("single_infl_a", 64'(inflight), 64'd1);
        phase(); #1;
        chk("single_infl_b", 64'(inflight), 64'd1);
        chk("single_early", 64'(rsp_valid), 64'h0);
        phase(); #1;
        chk("single_infl_c", 64'(inflight), 64'd1);
        phase(); #1;
        chk("single_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("single_sum", 64'(rsp_sum), 64'd3);
        chk("single_cout", 64'(rsp_cout), 64'h0);
        chk("single_infl_d", 64'(inflight), 64'd1);

        // Backpressure: req0 5+6+1, req1 ffffffff+1, head req0 stalled 2 cycles
        phase(); #1;
        chk("single_infl_e", 64'(inflight), 64'd0);
        chk("single_retired", 64'(rsp_valid), 64'h0);
        req_valid = 2'b01; req_a = {32'hffff_ffff, 32'd5}; req_b = {32'd1, 32'd6}; req_cin = 2'b01; #1;
        chk("bp_grant0", 64'(req_ready), 64'h1);
        phase(); req_valid = 2'b10; #1;
        chk("bp_grant1", 64'(req_ready), 64'h2);
        phase(); req_valid = 2'b00;
        phase();
        phase(); rsp_ready = 2'b10; req_valid = 2'b01; req_a[31:0] = 32'd7; req_b[31:0] = 32'd8; req_cin = 2'b00; #1;
        chk("bp_suspend_a", 64'(add_suspend), 64'hf);
        chk("bp_allow_a", 64'(add_out_allow), 64'h0);
        chk("bp_noissue_a", 64'(req_ready), 64'h0);
        chk("bp_sum_a", 64'(rsp_sum), 64'd12);
        chk("bp_valid_a", 64'(rsp_valid), 64'h1);
        phase(); #1;
        chk("bp_suspend_b", 64'(add_suspend), 64'hf);
        chk("bp_noissue_b", 64'(req_ready), 64'h0);
        chk("bp_sum_b", 64'(rsp_sum), 64'd12);
        chk("bp_infl_b", 64'(inflight), 64'd2);
        phase(); rsp_ready = 2'b11; #1;
        chk("bp_release", 64'(add_suspend), 64'h0);
        chk("bp_issue", 64'(req_ready), 64'h1);
        chk("bp_head_valid", 64'(rsp_valid), 64'h1);
        chk("bp_head_sum", 64'(rsp_sum), 64'd12);
        phase(); req_valid = 2'b00; #1;
        chk("bp_second_valid", 64'(rsp_valid), 64'h2);
        chk("bp_second_sum", 64'(rsp_sum), 64'd0);
        chk("bp_second_cout", 64'(rsp_cout), 64'h1);
        phase(); #1;
        chk("bp_gap", 64'(rsp_valid), 64'h0);
        phase();
        phase(); #1;
        chk("bp_third_valid", 64'(rsp_valid), 64'h1);
        chk("bp_third_sum", 64'(rsp_sum), 64'd15);

        // Flush: req0, req1, req0 then flush[0]
        phase(); req_valid = 2'b01; req_a = {32'd200, 32'd100}; req_b = {32'd2, 32'd1}; #1;
        chk("fl_g0", 64'(req_ready), 64'h1);
        phase(); req_valid = 2'b10; #1;
        chk("fl_g1", 64'(req_ready), 64'h2);
        phase(); req_valid = 2'b01; #1;
        chk("fl_g2", 64'(req_ready), 64'h1);
        phase(); flush = 2'b01; #1;
        chk("fl_beats_valid", 64'(req_ready), 64'h0);
        chk("fl_refresh", 64'(add_refresh), 64'h5);
        chk("fl_infl_before", 64'(inflight), 64'd3);
        phase(); flush = 2'b00; req_valid = 2'b00; #1;
        chk("fl_infl_after", 64'(inflight), 64'd1);
        chk("fl_no_rsp", 64'(rsp_valid), 64'h0);
        phase(); #1;
        chk("fl_survivor_valid", 64'(rsp_valid), 64'h2);
        chk("fl_survivor_sum", 64'(rsp_sum), 64'd202);
        phase(); #1;
        chk("fl_empty", 64'(inflight), 64'd0);
        chk("fl_done", 64'(rsp_valid), 64'h0);

        // Flush of a stalled req1 head
        req_valid = 2'b10; req_a = {32'd50, 32'd0}; req_b = {32'd5, 32'd0}; #1;
        chk("fs_grant", 64'(req_ready), 64'h2);
        phase(); req_valid = 2'b00;
        phase();
        phase();
        phase(); rsp_ready = 2'b01; #1;
        chk("fs_stall", 64'(add_suspend), 64'hf);
        chk("fs_head", 64'(rsp_valid), 64'h2);
        chk("fs_head_sum", 64'(rsp_sum), 64'd55);
        phase(); flush = 2'b10; #1;
        chk("fs_kill_valid", 64'(rsp_valid), 64'h0);
        chk("fs_kill_suspend", 64'(add_suspend), 64'h0);
        chk("fs_kill_allow", 64'(add_out_allow), 64'h1);
        chk("fs_kill_refresh", 64'(add_refresh), 64'h8);
        phase(); flush = 2'b00; rsp_ready = 2'b11; #1;
        chk("fs_empty", 64'(inflight), 64'd0);
        chk("fs_no_rsp", 64'(rsp_valid), 64'h0);
        phase(); #1;
        chk("fs_err", 64'(err), 64'h0);

        // Mid-operation reset with 3 ops in flight
        req_valid = 2'b01; req_a = {32'd2, 32'd1}; req_b = {32'd2, 32'd1}; #1;
        chk("mr_g0", 64'(req_ready), 64'h1);
        phase(); req_valid = 2'b10; #1;
        chk("mr_g1", 64'(req_ready), 64'h2);
        phase(); req_valid = 2'b01; #1;
        chk("mr_g2", 64'(req_ready), 64'h1);
        phase(); req_valid = 2'b11; #1;
        chk("mr_infl_pre", 64'(inflight), 64'd3);
        #1 rst = 1'b0; #1;
        chk("mr_infl", 64'(inflight), 64'd0);
        chk("mr_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("mr_req_ready", 64'(req_ready), 64'h0);
        chk("mr_validin", 64'(add_validin), 64'h0);
        chk("mr_suspend", 64'(add_suspend), 64'h0);
        chk("mr_allow", 64'(add_out_allow), 64'h1);
        repeat (2) phase();
        rst = 1'b1; req_valid = 2'b00; #1;
        chk("mr_purge", 64'(add_refresh), 64'hf);
        for (int k = 0; k < 6; k++) begin
            phase(); #1;
            chk($sformatf("mr_quiet_%0d", k), 64'(rsp_valid), 64'h0);
        end
        chk("mr_err", 64'(err), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
